// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and count-width helper for the programmable FIFO
package fifo_pkg;
  localparam int FIFO_STD = 0;
  localparam int FIFO_FWFT = 1;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register array with one write port and one asynchronous read port
module fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  // storage is deliberately unreset; validity is tracked by the pointers
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: any-depth single-clock FIFO with programmable thresholds and FWFT option
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT = FIFO_STD,
  localparam int CNT_W = cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  input  logic                  clr_sticky,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ovf_sticky,
  output logic                  udf_sticky,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] rd_data, dout_q;
  logic wr_ok, rd_ok, ovf_d, udf_d;
  assign full = count == CNT_W'(FIFO_DEPTH);
  assign empty = count == '0;
  assign almostfull = count >= af_thresh && !full;
  assign almostempty = count <= ae_thresh && !empty;
  // flush suppresses every transfer and status pulse in its cycle
  assign wr_ok = wr_en && !full && !flush;
  assign rd_ok = rd_en && !empty && !flush;
  assign ovf_d = wr_en && full && !flush;
  assign udf_d = rd_en && empty && !flush;
  // FWFT shows the head word directly; zero while empty keeps the reset value visible
  assign data_out = (FWFT == FIFO_FWFT) ? (empty ? '0 : rd_data) : dout_q;
  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_mem (
    .clk(clk), .we(wr_ok), .waddr(wr_ptr), .wdata(data_in), .raddr(rd_ptr), .rdata(rd_data)
  );
  // pointers, fill level and registered read data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      dout_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      if (rd_ok) dout_q <= rd_data;
      count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end
  // status pulses and sticky error flags; a new error wins over clr_sticky
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ack <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      wr_ack <= wr_ok;
      overflow <= ovf_d;
      underflow <= udf_d;
      ovf_sticky <= ovf_d || (ovf_sticky && !clr_sticky);
      udf_sticky <= udf_d || (udf_sticky && !clr_sticky);
    end
endmodule
